// File: rtl/fe_redirect_ctrl.sv
// Front-end redirect sequencer: picks one of exception/branch/jump redirect
// requests and walks the front end through flush, PC redirect and refill.
module fe_redirect_ctrl #(
    parameter int PC_WIDTH     = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 exc_req,
    input  logic [PC_WIDTH-1:0]  exc_pc,
    input  logic                 br_req,
    input  logic [PC_WIDTH-1:0]  br_pc,
    input  logic                 jmp_req,
    input  logic [PC_WIDTH-1:0]  jmp_pc,
    input  logic                 hold,
    input  logic                 if_wr,
    output logic                 exc_ack,
    output logic                 br_ack,
    output logic                 jmp_ack,
    output logic                 flush,
    output logic                 fe_stall,
    output logic                 branch_out,
    output logic                 jump_out,
    output logic                 exception_out,
    output logic [PC_WIDTH-1:0]  pc_override,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] redirect_cnt
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_REFILL   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        K_EXC = 2'd0,
        K_BR  = 2'd1,
        K_JMP = 2'd2
    } kind_t;

    state_t                state_r, state_s;
    kind_t                 kind_r, kind_s;
    logic [PC_WIDTH-1:0]   pc_r, pc_s;
    logic [FC_W-1:0]       fcnt_r, fcnt_s;
    logic                  exc_ack_r, exc_ack_s;
    logic                  br_ack_r, br_ack_s;
    logic                  jmp_ack_r, jmp_ack_s;
    logic                  flush_r, flush_s;
    logic                  fe_stall_r, fe_stall_s;
    logic                  branch_r, branch_s;
    logic                  jump_r, jump_s;
    logic                  exception_r, exception_s;
    logic [PC_WIDTH-1:0]   pc_override_r, pc_override_s;
    logic                  busy_r, busy_s;
    logic [CNT_WIDTH-1:0]  redirect_cnt_r, redirect_cnt_s;

    // Next-state and next-output computation for the redirect sequence.
    always_comb begin
        state_s        = state_r;
        kind_s         = kind_r;
        pc_s           = pc_r;
        fcnt_s         = fcnt_r;
        exc_ack_s      = 1'b0;
        br_ack_s       = 1'b0;
        jmp_ack_s      = 1'b0;
        branch_s       = 1'b0;
        jump_s         = 1'b0;
        exception_s    = 1'b0;
        pc_override_s  = pc_override_r;
        redirect_cnt_s = redirect_cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (exc_req) begin
                    state_s   = ST_FLUSH;
                    kind_s    = K_EXC;
                    pc_s      = exc_pc;
                    fcnt_s    = FC_LOAD;
                    exc_ack_s = 1'b1;
                end else if (br_req) begin
                    state_s   = ST_FLUSH;
                    kind_s    = K_BR;
                    pc_s      = br_pc;
                    fcnt_s    = FC_LOAD;
                    br_ack_s  = 1'b1;
                end else if (jmp_req) begin
                    state_s   = ST_FLUSH;
                    kind_s    = K_JMP;
                    pc_s      = jmp_pc;
                    fcnt_s    = FC_LOAD;
                    jmp_ack_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                // An exception replaces a pending branch/jump and restarts the flush window.
                if (exc_req && (kind_r != K_EXC)) begin
                    kind_s    = K_EXC;
                    pc_s      = exc_pc;
                    fcnt_s    = FC_LOAD;
                    exc_ack_s = 1'b1;
                end else if (fcnt_r == {FC_W{1'b0}}) begin
                    state_s = ST_REDIRECT;
                end else begin
                    fcnt_s = fcnt_r - FC_W'(1);
                end
            end
            ST_REDIRECT: begin
                if (hold) begin
                    state_s = ST_REDIRECT;
                end else begin
                    state_s       = ST_REFILL;
                    pc_override_s = pc_r;
                    case (kind_r)
                        K_EXC:   exception_s = 1'b1;
                        K_BR:    branch_s    = 1'b1;
                        K_JMP:   jump_s      = 1'b1;
                        default: exception_s = 1'b0;
                    endcase
                    if (redirect_cnt_r != {CNT_WIDTH{1'b1}}) begin
                        redirect_cnt_s = redirect_cnt_r + CNT_WIDTH'(1);
                    end else begin
                        redirect_cnt_s = redirect_cnt_r;
                    end
                end
            end
            ST_REFILL: begin
                if (exc_req) begin
                    state_s   = ST_FLUSH;
                    kind_s    = K_EXC;
                    pc_s      = exc_pc;
                    fcnt_s    = FC_LOAD;
                    exc_ack_s = 1'b1;
                end else if (if_wr) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_REFILL;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        flush_s    = (state_s == ST_FLUSH);
        fe_stall_s = (state_s == ST_FLUSH) || (state_s == ST_REDIRECT);
        busy_s     = (state_s != ST_IDLE);
    end

    // State and registered-output update; reset aborts any sequence silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            kind_r         <= K_EXC;
            pc_r           <= {PC_WIDTH{1'b0}};
            fcnt_r         <= {FC_W{1'b0}};
            exc_ack_r      <= 1'b0;
            br_ack_r       <= 1'b0;
            jmp_ack_r      <= 1'b0;
            flush_r        <= 1'b0;
            fe_stall_r     <= 1'b0;
            branch_r       <= 1'b0;
            jump_r         <= 1'b0;
            exception_r    <= 1'b0;
            pc_override_r  <= {PC_WIDTH{1'b0}};
            busy_r         <= 1'b0;
            redirect_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r        <= state_s;
            kind_r         <= kind_s;
            pc_r           <= pc_s;
            fcnt_r         <= fcnt_s;
            exc_ack_r      <= exc_ack_s;
            br_ack_r       <= br_ack_s;
            jmp_ack_r      <= jmp_ack_s;
            flush_r        <= flush_s;
            fe_stall_r     <= fe_stall_s;
            branch_r       <= branch_s;
            jump_r         <= jump_s;
            exception_r    <= exception_s;
            pc_override_r  <= pc_override_s;
            busy_r         <= busy_s;
            redirect_cnt_r <= redirect_cnt_s;
        end
    end

    assign exc_ack       = exc_ack_r;
    assign br_ack        = br_ack_r;
    assign jmp_ack       = jmp_ack_r;
    assign flush         = flush_r;
    assign fe_stall      = fe_stall_r;
    assign branch_out    = branch_r;
    assign jump_out      = jump_r;
    assign exception_out = exception_r;
    assign pc_override   = pc_override_r;
    assign busy          = busy_r;
    assign redirect_cnt  = redirect_cnt_r;

endmodule

// File: tb/tb_fe_redirect_ctrl.sv
// Bench for fe_redirect_ctrl: directed reset/flush checks, then random request
// traffic scored against a cycle-time reference model through ack/redirect queues.
module tb_fe_redirect_ctrl;

    localparam int PW      = 32;
    localparam int FC      = 2;
    localparam int CW      = 2;
    localparam int NREQ    = 10;
    localparam int LEN     = 3000;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct {
        int kind;
        int t;
    } ack_t;

    typedef struct {
        int          kind;
        logic [PW-1:0] pc;
        int          t;
        int          cnt;
    } redir_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          exc_req = 1'b0, br_req = 1'b0, jmp_req = 1'b0;
    logic [PW-1:0] exc_pc = '0, br_pc = '0, jmp_pc = '0;
    logic          hold = 1'b0, if_wr = 1'b0;
    logic          exc_ack, br_ack, jmp_ack, flush, fe_stall;
    logic          branch_out, jump_out, exception_out, busy;
    logic [PW-1:0] pc_override;
    logic [CW-1:0] redirect_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;
    bit sb_on = 1'b0;

    ack_t   exp_ack[$];
    redir_t exp_rd[$];

    int            sched[3][NREQ];
    logic [PW-1:0] spc[3][NREQ];
    bit            hold_seq[LEN];
    bit            ifw_seq[LEN];
    int            m_head[3];
    int            m_last[3];
    logic [PW-1:0] m_pc;
    int            model_end;

    fe_redirect_ctrl #(.PC_WIDTH(PW), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .exc_req(exc_req), .exc_pc(exc_pc),
        .br_req(br_req), .br_pc(br_pc),
        .jmp_req(jmp_req), .jmp_pc(jmp_pc),
        .hold(hold), .if_wr(if_wr),
        .exc_ack(exc_ack), .br_ack(br_ack), .jmp_ack(jmp_ack),
        .flush(flush), .fe_stall(fe_stall),
        .branch_out(branch_out), .jump_out(jump_out), .exception_out(exception_out),
        .pc_override(pc_override), .busy(busy), .redirect_cnt(redirect_cnt)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit hold_at(input int t);
        return (t >= 0 && t < LEN) ? hold_seq[t] : 1'b0;
    endfunction

    function automatic bit ifw_at(input int t);
        return (t >= 0 && t < LEN) ? ifw_seq[t] : 1'b1;
    endfunction

    function automatic bit remain(input int k);
        return m_head[k] < NREQ;
    endfunction

    // a requester raises its next request no earlier than the cycle after its last ack
    function automatic int eff(input int k);
        int s;
        s = sched[k][m_head[k]];
        return (s > m_last[k]) ? s : m_last[k] + 1;
    endfunction

    task automatic m_take(input int k, input int at);
        ack_t e;
        e.kind = k;
        e.t    = at;
        exp_ack.push_back(e);
        m_last[k] = at;
        m_pc      = spc[k][m_head[k]];
        m_head[k]++;
    endtask

    // Walks redirect episodes as time windows: accept, flush window, hold wait, refill wait.
    task automatic run_model();
        int t, a, fend, tr, p, tf, w, best, cnt;
        bit in_seq;
        redir_t rd;
        t   = 0;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            m_head[k] = 0;
            m_last[k] = -1;
        end
        while (remain(0) || remain(1) || remain(2)) begin
            best = 1 << 30;
            for (int k = 0; k < 3; k++)
                if (remain(k) && eff(k) < best) best = eff(k);
            if (best > t) t = best;
            w = -1;
            for (int k = 0; k < 3; k++)
                if (w < 0 && remain(k) && eff(k) <= t) w = k;
            a = t + 1;
            m_take(w, a);
            in_seq = 1'b1;
            while (in_seq) begin
                fend = a + FC - 1;
                if (w != 0 && remain(0) && eff(0) <= fend) begin
                    a = ((eff(0) > a) ? eff(0) : a) + 1;
                    w = 0;
                    m_take(0, a);
                end else begin
                    tr = fend + 1;
                    while (hold_at(tr)) tr++;
                    p   = tr + 1;
                    cnt = (cnt < CNT_MAX) ? cnt + 1 : CNT_MAX;
                    rd.kind = w;
                    rd.pc   = m_pc;
                    rd.t    = p;
                    rd.cnt  = cnt;
                    exp_rd.push_back(rd);
                    tf = p;
                    while (!(remain(0) && eff(0) <= tf) && !ifw_at(tf)) tf++;
                    if (remain(0) && eff(0) <= tf) begin
                        a = tf + 1;
                        w = 0;
                        m_take(0, a);
                    end else begin
                        t      = tf + 1;
                        in_seq = 1'b0;
                    end
                end
            end
        end
        model_end = t;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an ack or a redirect pulse.
    initial begin
        int r;
        logic [2:0] av, ov;
        ack_t ea;
        redir_t er;
        forever begin
            @(negedge clk);
            if (sb_on) begin
                r  = cyc - t0;
                av = {exc_ack, br_ack, jmp_ack};
                ov = {exception_out, branch_out, jump_out};
                if (av != 3'b000) begin
                    if (exp_ack.size() == 0) begin
                        chk("ack_extra", 64'(av), 64'd0);
                    end else begin
                        ea = exp_ack.pop_front();
                        chk("ack_kind", 64'(av), 64'(3'b100 >> ea.kind));
                        chk("ack_time", 64'(r), 64'(ea.t));
                    end
                end
                if (ov != 3'b000) begin
                    if (exp_rd.size() == 0) begin
                        chk("redir_extra", 64'(ov), 64'd0);
                    end else begin
                        er = exp_rd.pop_front();
                        chk("redir_kind", 64'(ov), 64'(3'b100 >> er.kind));
                        chk("redir_time", 64'(r), 64'(er.t));
                        chk("redir_pc", 64'(pc_override), 64'(er.pc));
                        chk("redir_cnt", 64'(redirect_cnt), 64'(er.cnt));
                        chk("redir_stall", 64'(fe_stall), 64'd0);
                    end
                end
            end
        end
    end

    initial begin
        bit            req_v[3];
        logic [PW-1:0] pc_v[3];
        int            drv_head[3];
        logic [2:0]    acks_now;
        int            s;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_stall", 64'(fe_stall), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pc", 64'(pc_override), 64'd0);
        chk("rst_cnt", 64'(redirect_cnt), 64'd0);
        chk("rst_pulses", 64'({exc_ack, br_ack, jmp_ack, exception_out, branch_out, jump_out}), 64'd0);

        // branch request, then reset in the middle of its flush
        rst    = 1'b0;
        br_req = 1'b1;
        br_pc  = 32'h0000_0100;
        @(negedge clk);
        chk("d_ack", 64'(br_ack), 64'd1);
        chk("d_flush1", 64'(flush), 64'd1);
        chk("d_stall1", 64'(fe_stall), 64'd1);
        chk("d_busy1", 64'(busy), 64'd1);
        @(negedge clk);
        chk("d_flush2", 64'(flush), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_flush", 64'(flush), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_pc", 64'(pc_override), 64'd0);
        chk("mid_rst_cnt", 64'(redirect_cnt), 64'd0);
        chk("mid_rst_out", 64'(branch_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("restart_ack", 64'(br_ack), 64'd1);
        br_req = 1'b0;
        @(negedge clk);
        chk("restart_flush", 64'(flush), 64'd1);
        chk("restart_ack_once", 64'(br_ack), 64'd0);
        @(negedge clk);
        chk("redirect_flush", 64'(flush), 64'd0);
        chk("redirect_stall", 64'(fe_stall), 64'd1);
        chk("redirect_nopulse", 64'(branch_out), 64'd0);
        @(negedge clk);
        chk("d_pulse", 64'({exception_out, branch_out, jump_out}), 64'(3'b010));
        chk("d_pc", 64'(pc_override), 64'h100);
        chk("d_cnt", 64'(redirect_cnt), 64'd1);
        chk("d_refill_stall", 64'(fe_stall), 64'd0);
        if_wr = 1'b1;
        @(negedge clk);
        if_wr = 1'b0;
        chk("d_idle", 64'(busy), 64'd0);
        chk("d_pulse_off", 64'(branch_out), 64'd0);
        chk("d_pc_hold", 64'(pc_override), 64'h100);

        // random traffic: first requests of all three kinds collide in one cycle
        for (int k = 0; k < 3; k++) begin
            s = 3;
            for (int i = 0; i < NREQ; i++) begin
                if (i > 0) s = s + int'($urandom_range(0, 60));
                sched[k][i] = s;
                spc[k][i]   = $urandom;
            end
        end
        for (int i = 0; i < LEN; i++) begin
            hold_seq[i] = ($urandom_range(0, 9) < 4);
            ifw_seq[i]  = ($urandom_range(0, 9) < 3);
        end
        run_model();

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        t0    = cyc;
        sb_on = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_v[k]    = 1'b0;
            pc_v[k]     = '0;
            drv_head[k] = 0;
        end
        for (int r = 0; r <= model_end + 20; r++) begin
            acks_now = {exc_ack, br_ack, jmp_ack};
            for (int k = 0; k < 3; k++) begin
                if (req_v[k] && acks_now[2-k]) begin
                    req_v[k] = 1'b0;
                    drv_head[k]++;
                end else if (!req_v[k] && drv_head[k] < NREQ && sched[k][drv_head[k]] <= r) begin
                    req_v[k] = 1'b1;
                    pc_v[k]  = spc[k][drv_head[k]];
                end
            end
            exc_req = req_v[0];
            exc_pc  = pc_v[0];
            br_req  = req_v[1];
            br_pc   = pc_v[1];
            jmp_req = req_v[2];
            jmp_pc  = pc_v[2];
            hold    = hold_at(r);
            if_wr   = ifw_at(r);
            @(negedge clk);
        end
        sb_on = 1'b0;
        chk("acks_left", 64'(exp_ack.size()), 64'd0);
        chk("redirs_left", 64'(exp_rd.size()), 64'd0);
        chk("end_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
